// File: rtl/unsat_clause_selector.sv
`default_nettype none
// ============================================================================
// Module   : unsat_clause_selector
// Purpose  : Drains the unsatisfied-clause FIFO tree on each start, counts the
//            clauses popped and keeps one of them chosen uniformly at random
//            (reservoir sampling driven by a free-running 16-bit Galois LFSR).
//            Reports the chosen clause, or that no unsatisfied clause exists.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   start          in   one-cycle pulse; begins a round when idle
//   fifo_empty_i   in   FIFO tree empty flag
//   fifo_clause_i  in   FIFO tree read data (valid the cycle after a read)
//   fifo_rden_o    out  FIFO tree read enable
//   busy_o         out  round in progress (through the done cycle)
//   done_o         out  one-cycle end-of-round pulse
//   sat_o          out  with done_o: no clause was popped
//   clause_o       out  selected clause, held until the next done_o
//   count_o        out  clauses popped last round (saturating)
// ============================================================================
module unsat_clause_selector #(
   parameter int          CLAUSE_WIDTH  = 36,
   parameter int          CNT_WIDTH     = 8,
   parameter int          SETTLE_CYCLES = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    fifo_empty_i,
   input  logic [CLAUSE_WIDTH-1:0] fifo_clause_i,
   output logic                    fifo_rden_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    sat_o,
   output logic [CLAUSE_WIDTH-1:0] clause_o,
   output logic [CNT_WIDTH-1:0]    count_o
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_drain = 2'd1;
   localparam logic [1:0] c_done  = 2'd2;

   localparam logic [15:0]          c_lfsr_mask     = 16'hB400;
   localparam int                   c_prod_w        = 16 + CNT_WIDTH;
   localparam logic [c_prod_w-1:0]  c_keep_limit    = c_prod_w'(32'h0001_0000);
   localparam logic [CNT_WIDTH-1:0] c_cnt_max       = '1;
   localparam logic [7:0]           c_settle_target = 8'(SETTLE_CYCLES);

   logic [1:0]              r_state;
   logic [15:0]             r_lfsr;
   logic                    r_rd_pend;
   logic [CNT_WIDTH-1:0]    r_k;
   logic [7:0]              r_settle;
   logic [CLAUSE_WIDTH-1:0] r_cand;

   logic [15:0]             w_lfsr_next;
   logic [CNT_WIDTH-1:0]    w_k_next;
   logic [c_prod_w-1:0]     w_product;
   logic                    w_keep;
   logic [7:0]              w_settle_next;

   // Galois LFSR, right-shifting; feedback taps folded in when the LSB is 1.
   assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_mask) : (r_lfsr >> 1);

   assign w_k_next = (r_k == c_cnt_max) ? r_k : (r_k + CNT_WIDTH'(1));

   // Keep the k-th clause when lfsr * k < 2^16, i.e. with probability ~1/k.
   // Full-width product so a large count never wraps into a false keep.
   assign w_product = {{CNT_WIDTH{1'b0}}, r_lfsr} * {16'h0000, w_k_next};
   assign w_keep    = (w_product < c_keep_limit);

   // The drain is only over once the FIFO stays empty with no read in flight.
   assign w_settle_next = (fifo_empty_i && !r_rd_pend) ? (r_settle + 8'd1) : 8'd0;

   assign fifo_rden_o = (r_state == c_drain) && !fifo_empty_i;
   assign busy_o      = (r_state != c_idle);
   assign done_o      = (r_state == c_done);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= c_idle;
         r_lfsr    <= LFSR_SEED;
         r_rd_pend <= 1'b0;
         r_k       <= '0;
         r_settle  <= 8'd0;
         r_cand    <= '0;
         clause_o  <= '0;
         count_o   <= '0;
         sat_o     <= 1'b0;
      end else begin
         r_lfsr    <= w_lfsr_next;
         r_rd_pend <= fifo_rden_o;
         case (r_state)
            c_idle: begin
               if (start) begin
                  r_state  <= c_drain;
                  r_k      <= '0;
                  r_settle <= 8'd0;
                  sat_o    <= 1'b0;
               end
            end
            c_drain: begin
               if (r_rd_pend) begin
                  r_k <= w_k_next;
                  if (w_keep) begin
                     r_cand <= fifo_clause_i;
                  end
               end
               r_settle <= w_settle_next;
               // Results are loaded on entry to DONE so they are valid
               // alongside done_o. No data can be returning here: the settle
               // counter only advances while nothing is pending.
               if (w_settle_next == c_settle_target) begin
                  r_state <= c_done;
                  count_o <= r_k;
                  sat_o   <= (r_k == '0);
                  if (r_k != '0) begin
                     clause_o <= r_cand;
                  end
               end
            end
            c_done: begin
               r_state <= c_idle;
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_unsat_clause_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_unsat_clause_selector
// Purpose  : Directed self-checking bench for unsat_clause_selector with a
//            behavioural FIFO tree and an independent reservoir/LFSR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unsat_clause_selector;

   localparam int          CLAUSE_WIDTH  = 36;
   localparam int          CNT_WIDTH     = 8;
   localparam int          SETTLE_CYCLES = 8;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic                    fifo_empty_i = 1'b1;
   logic [CLAUSE_WIDTH-1:0] fifo_clause_i = '0;
   logic                    fifo_rden_o;
   logic                    busy_o;
   logic                    done_o;
   logic                    sat_o;
   logic [CLAUSE_WIDTH-1:0] clause_o;
   logic [CNT_WIDTH-1:0]    count_o;

   int checks = 0;
   int errors = 0;

   // FIFO tree model and reference selection model
   logic [CLAUSE_WIDTH-1:0] mem [0:511];
   int                      rp = 0;
   int                      wp = 0;
   int                      pops = 0;
   int                      underflow = 0;
   logic                    rd_prev;
   logic                    rst_prev;
   logic [15:0]             m_lfsr = 16'h0000;
   int                      m_k = 0;
   logic [CLAUSE_WIDTH-1:0] m_cand = '0;

   unsat_clause_selector #(
      .CLAUSE_WIDTH (CLAUSE_WIDTH),
      .CNT_WIDTH    (CNT_WIDTH),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .LFSR_SEED    (LFSR_SEED)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .fifo_empty_i (fifo_empty_i),
      .fifo_clause_i(fifo_clause_i),
      .fifo_rden_o  (fifo_rden_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .sat_o        (sat_o),
      .clause_o     (clause_o),
      .count_o      (count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Read enable is sampled just before the edge; the popped word is
   // presented just after the following edge (one-cycle read latency).
   initial begin
      int knext;
      forever begin
         @(negedge clk);
         #4;
         rd_prev  = fifo_rden_o;
         rst_prev = reset;
         @(posedge clk);
         #1;
         if (rst_prev) m_lfsr = LFSR_SEED;
         else          m_lfsr = lfsr_step(m_lfsr);
         if (rd_prev && !rst_prev) begin
            if (rp >= wp) begin
               underflow++;
            end else begin
               fifo_clause_i = mem[rp];
               rp++;
               pops++;
               knext = (m_k >= 255) ? 255 : m_k + 1;
               if (longint'(m_lfsr) * longint'(knext) < 64'd65536) m_cand = fifo_clause_i;
               m_k = knext;
            end
         end
         fifo_empty_i = (rp >= wp);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic run_round(input int budget, output int cyc, output bit got);
      @(negedge clk);
      start = 1'b1;
      m_k   = 0;
      cyc   = 0;
      got   = 1'b0;
      while (cyc < budget && !got) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (done_o === 1'b1) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 6;
      if (fifo_rden_o !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b expected 0", fifo_rden_o); end
      if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      if (done_o !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
      if (sat_o !== 1'b0)       begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_o); end
      if (clause_o !== '0)      begin errors++; $display("FAIL reset_clause: got %h expected 0", clause_o); end
      if (count_o !== '0)       begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
      reset = 1'b0;
      m_k = 0;
   endtask

   task automatic test_empty(input logic [CLAUSE_WIDTH-1:0] exp_clause);
      int cyc; bit got; int p0;
      p0 = pops;
      run_round(40, cyc, got);
      checks += 6;
      if (!got || cyc != SETTLE_CYCLES + 1) begin
         errors++; $display("FAIL empty_latency: got %0d cycles (seen=%0b) expected %0d", cyc, got, SETTLE_CYCLES + 1);
      end
      if (sat_o !== 1'b1)         begin errors++; $display("FAIL empty_sat: got %b expected 1", sat_o); end
      if (count_o !== 8'd0)       begin errors++; $display("FAIL empty_count: got %0d expected 0", count_o); end
      if (clause_o !== exp_clause) begin errors++; $display("FAIL empty_clause_hold: got %h expected %h", clause_o, exp_clause); end
      if (busy_o !== 1'b1)        begin errors++; $display("FAIL empty_busy_at_done: got %b expected 1", busy_o); end
      if (pops != p0)             begin errors++; $display("FAIL empty_no_read: got %0d reads expected 0", pops - p0); end
   endtask

   task automatic test_single();
      int cyc; bit got; int p0;
      p0 = pops; rp = 0; wp = 0;
      mem[0] = 36'h0_1234_5678;
      wp = 1;
      run_round(60, cyc, got);
      checks += 5;
      if (!got)                          begin errors++; $display("FAIL single_done: got no done expected done"); end
      if (sat_o !== 1'b0)                begin errors++; $display("FAIL single_sat: got %b expected 0", sat_o); end
      if (count_o !== 8'd1)              begin errors++; $display("FAIL single_count: got %0d expected 1", count_o); end
      if (clause_o !== 36'h0_1234_5678)  begin errors++; $display("FAIL single_clause: got %h expected 012345678", clause_o); end
      if (pops - p0 != 1 || underflow != 0) begin
         errors++; $display("FAIL single_reads: got %0d reads (%0d underflow) expected 1", pops - p0, underflow);
      end
   endtask

   task automatic test_late_arrival();
      int cyc; bit got; int p0; int phase; int cnt; bit found;
      p0 = pops; rp = 0; wp = 0;
      for (int i = 0; i < 5; i++) mem[i] = 36'hA_0000_0001 + 36'(i);
      wp = 3;
      @(negedge clk);
      start = 1'b1; m_k = 0;
      phase = 0; cnt = 0; got = 1'b0; cyc = 0;
      while (cyc < 200 && !got) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (phase == 0 && rp == 3 && fifo_empty_i) begin
            phase = 1; cnt = 0;
         end else if (phase == 1) begin
            cnt++;
            if (cnt == 3) begin wp = 5; phase = 2; end
         end
         if (done_o === 1'b1) got = 1'b1;
      end
      found = 1'b0;
      for (int i = 0; i < 5; i++) if (clause_o === mem[i]) found = 1'b1;
      checks += 5;
      if (!got || phase != 2)    begin errors++; $display("FAIL late_done: got done=%0b phase=%0d expected done after late data", got, phase); end
      if (count_o !== 8'd5)      begin errors++; $display("FAIL late_count: got %0d expected 5", count_o); end
      if (pops - p0 != 5)        begin errors++; $display("FAIL late_reads: got %0d expected 5", pops - p0); end
      if (!found)                begin errors++; $display("FAIL late_member: got %h expected one of the 5 inputs", clause_o); end
      if (clause_o !== m_cand)   begin errors++; $display("FAIL late_select: got %h expected %h", clause_o, m_cand); end
   endtask

   task automatic test_uniformity();
      int hits [4];
      int n; int cyc; bit got;
      for (int j = 0; j < 4; j++) hits[j] = 0;
      for (int r = 0; r < 1000; r++) begin
         rp = 0; wp = 0;
         for (int j = 0; j < 4; j++) mem[j] = {4'hC, 16'(r), 16'(j)};
         @(negedge clk);
         start = 1'b1; m_k = 0;
         @(negedge clk);
         start = 1'b0;
         for (int j = 0; j < 4; j++) begin
            wp = j + 1;
            n = 0;
            while (rp < j + 1 && n < 20) begin @(negedge clk); n++; end
            if (rp < j + 1) begin
               checks++; errors++;
               $display("FAIL uni_pop_timeout: round %0d got %0d pops expected %0d", r, rp, j + 1);
            end
            repeat ($urandom_range(2, 5)) @(negedge clk);
         end
         cyc = 0; got = (done_o === 1'b1);
         while (cyc < 40 && !got) begin
            @(negedge clk); cyc++;
            if (done_o === 1'b1) got = 1'b1;
         end
         checks += 2;
         if (!got || count_o !== 8'd4) begin
            errors++; $display("FAIL uni_count: round %0d got %0d (done=%0b) expected 4", r, count_o, got);
         end
         if (clause_o !== m_cand) begin
            errors++; $display("FAIL uni_select: round %0d got %h expected %h", r, clause_o, m_cand);
         end
         if (clause_o[15:0] < 16'd4) hits[clause_o[1:0]]++;
      end
      $display("uniformity hits: %0d %0d %0d %0d", hits[0], hits[1], hits[2], hits[3]);
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (hits[j] < 190 || hits[j] > 310) begin
            errors++; $display("FAIL uni_bucket%0d: got %0d expected 250 +/- 60", j, hits[j]);
         end
      end
   endtask

   task automatic test_saturation();
      int cyc; bit got; int p0;
      p0 = pops; rp = 0; wp = 0;
      for (int i = 0; i < 300; i++) mem[i] = {4'h5, 32'(i)};
      wp = 300;
      run_round(500, cyc, got);
      checks += 5;
      if (!got)                 begin errors++; $display("FAIL sat_done: got no done expected done"); end
      if (count_o !== 8'd255)   begin errors++; $display("FAIL sat_count: got %0d expected 255", count_o); end
      if (pops - p0 != 300)     begin errors++; $display("FAIL sat_reads: got %0d expected 300", pops - p0); end
      if (fifo_empty_i !== 1'b1 || rp != 300) begin
         errors++; $display("FAIL sat_fifo_empty: got empty=%b rp=%0d expected empty=1 rp=300", fifo_empty_i, rp);
      end
      if (clause_o !== m_cand)  begin errors++; $display("FAIL sat_select: got %h expected %h", clause_o, m_cand); end
   endtask

   task automatic test_reset_mid_round();
      int dones;
      rp = 0; wp = 0;
      for (int i = 0; i < 10; i++) mem[i] = {4'h7, 32'(i)};
      wp = 10;
      @(negedge clk);
      start = 1'b1; m_k = 0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      rp = 0; wp = 0;
      @(negedge clk);
      checks += 6;
      if (fifo_rden_o !== 1'b0) begin errors++; $display("FAIL rst_mid_rden: got %b expected 0", fifo_rden_o); end
      if (busy_o !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_o); end
      if (done_o !== 1'b0)      begin errors++; $display("FAIL rst_mid_done: got %b expected 0", done_o); end
      if (sat_o !== 1'b0)       begin errors++; $display("FAIL rst_mid_sat: got %b expected 0", sat_o); end
      if (clause_o !== '0)      begin errors++; $display("FAIL rst_mid_clause: got %h expected 0", clause_o); end
      if (count_o !== '0)       begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", count_o); end
      reset = 1'b0;
      m_k = 0;
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_o === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", dones); end
   endtask

   task automatic test_start_while_busy();
      int dones; logic [7:0] cnt_seen; logic [CLAUSE_WIDTH-1:0] cl_seen;
      rp = 0; wp = 0;
      for (int i = 0; i < 3; i++) mem[i] = {4'h9, 32'(i + 16)};
      wp = 3;
      @(negedge clk);
      start = 1'b1; m_k = 0;
      dones = 0; cnt_seen = 8'hxx; cl_seen = 'x;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = (c == 3 || c == 6 || c == 10) ? 1'b1 : 1'b0;
         if (done_o === 1'b1) begin
            dones++; cnt_seen = count_o; cl_seen = clause_o;
         end
      end
      start = 1'b0;
      checks += 3;
      if (dones != 1)           begin errors++; $display("FAIL busy_start_dones: got %0d expected 1", dones); end
      if (cnt_seen !== 8'd3)    begin errors++; $display("FAIL busy_start_count: got %0d expected 3", cnt_seen); end
      if (cl_seen !== m_cand)   begin errors++; $display("FAIL busy_start_select: got %h expected %h", cl_seen, m_cand); end
   endtask

   initial begin
      test_reset();
      test_empty(36'h0);
      test_single();
      test_empty(36'h0_1234_5678);
      test_late_arrival();
      test_uniformity();
      test_saturation();
      test_reset_mid_round();
      test_start_while_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
